// File: rtl/serial_eq_ctrl_pkg.sv
// Shared types for the bit-serial equality sequencer.
// State encoding and index-width helper.
package serial_eq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/eq1.sv
// Single-bit equality cell.
// Used as the shared compare datapath of the serial sequencer.
module eq1 (
  input  logic i0,
  input  logic i1,
  output logic eq
);

  assign eq = (~i0 & ~i1) | (i0 & i1);

endmodule

// File: rtl/serial_eq_ctrl.sv
// Bit-serial W-bit equality checker: LSB-first through one eq1
// cell, early exit on first mismatch, one-cycle done pulse.
module serial_eq_ctrl
  import serial_eq_ctrl_pkg::*;
#(
  parameter  int W    = 8,
  localparam int IDXW = idx_w(W)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            eq,
  output logic [IDXW-1:0] mismatch_idx
);

  localparam logic [IDXW-1:0] LAST = IDXW'(W - 1);

  state_t          state, state_d;
  logic [W-1:0]    sa, sa_d;
  logic [W-1:0]    sb, sb_d;
  logic [IDXW-1:0] cnt, cnt_d;
  logic            eq_q, eq_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            bit_eq;

  eq1 u_eq1 (
    .i0 (sa[0]),
    .i1 (sb[0]),
    .eq (bit_eq)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      cnt   <= '0;
      eq_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      state <= state_d;
      sa    <= sa_d;
      sb    <= sb_d;
      cnt   <= cnt_d;
      eq_q  <= eq_d;
      idx_q <= idx_d;
    end
  end

  always_comb begin
    state_d = state;
    sa_d    = sa;
    sb_d    = sb;
    cnt_d   = cnt;
    eq_d    = eq_q;
    idx_d   = idx_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = '0;
          state_d = COMP;
        end
      end
      COMP: begin
        if (!bit_eq) begin
          eq_d    = 1'b0;
          idx_d   = cnt;
          state_d = DONE;
        end else if (cnt == LAST) begin
          eq_d    = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          sa_d  = sa >> 1;
          sb_d  = sb >> 1;
          cnt_d = cnt + IDXW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags decode straight from the state register.
  assign ready        = (state == IDLE);
  assign busy         = (state == COMP);
  assign done         = (state == DONE);
  assign eq           = eq_q;
  assign mismatch_idx = idx_q;

endmodule
